// File: rtl/gate_pair_bist_pkg.sv
// gate_pair_bist_pkg
//   Shared types and helpers for the gate-pair self-test engine.
//   - state_t : run sequencer states
//   - NUM_VEC : number of input vectors per sweep ({a,b} = 0..3)
//   - exp_zw  : golden {z,w} for a given {a,b} (z = a&b, w = a|b)
//   Optional feature macro used elsewhere: GATE_PAIR_BIST_FIRST_FAIL_EN.
package gate_pair_bist_pkg;

  localparam int NUM_VEC = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // vec[1] drives input a, vec[0] drives input b.
  function automatic logic [1:0] exp_zw(input logic [1:0] vec);
    return {vec[1] & vec[0], vec[1] | vec[0]};
  endfunction

endpackage

// File: rtl/gate_pair_bist_if.sv
// gate_pair_bist_if
//   Connection between the self-test engine and the AND/OR gate-pair block.
//   dut_a, dut_b : stimulus into the gate pair
//   dut_z        : gate-pair AND output
//   dut_w        : gate-pair OR output
//   Modports: master = test engine side, slave = gate-pair side.
interface gate_pair_bist_if;
  logic dut_a;
  logic dut_b;
  logic dut_z;
  logic dut_w;

  modport master (output dut_a, output dut_b, input dut_z, input dut_w);
  modport slave  (input dut_a, input dut_b, output dut_z, output dut_w);
endinterface

// File: rtl/gate_pair_bist_sat_cnt.sv
// gate_pair_bist_sat_cnt
//   Saturating up-counter used for the mismatch count.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear (count -> 0), same priority as rst
//   inc   : add one unless already at all-ones
//   count : current value, W bits
module gate_pair_bist_sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/gate_pair_bist.sv
// gate_pair_bist
//   Self-test engine for an AND/OR gate pair. Sweeps {a,b} = 00,01,10,11,
//   holds each vector SETTLE_CYCLES cycles, then checks z/w for one cycle.
//   Repeats ROUNDS times and reports pass/fail, a saturating error count and
//   a per-vector fail map.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     start      : begin a run from IDLE or DONE (ignored while busy)
//     gp         : gate-pair connection (master: drives dut_a/dut_b, reads dut_z/dut_w)
//     busy       : high in SETTLE and CHECK
//     done       : high in DONE until next start or rst
//     pass       : done with zero mismatches
//     err_count  : mismatching checks, saturating at 2^ERR_W-1
//     fail_vec   : bit i set if vector i mismatched in any round
//   Optional (macro GATE_PAIR_BIST_FIRST_FAIL_EN):
//     first_fail_valid, first_fail_vec[1:0], first_fail_zw[1:0] capture the
//     vector and observed {z,w} of the first mismatch in a run.
module gate_pair_bist
  import gate_pair_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 1,
  parameter int ERR_W         = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  gate_pair_bist_if.master   gp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [NUM_VEC-1:0] fail_vec
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
  ,
  output logic               first_fail_valid,
  output logic [1:0]         first_fail_vec,
  output logic [1:0]         first_fail_zw
`endif
);

  localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int ROUND_W = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(ROUNDS - 1);
  localparam logic [1:0]         VEC_LAST   = 2'(NUM_VEC - 1);

  state_t               state_q, state_d;
  logic [1:0]           vec_q, vec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [1:0]           ab_q, ab_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_VEC-1:0]   fail_vec_q, fail_vec_d;
  logic                 err_clr, err_inc;
  logic [1:0]           obs_zw;
  logic                 mismatch;
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
  logic                 ff_valid_q, ff_valid_d;
  logic [1:0]           ff_vec_q, ff_vec_d;
  logic [1:0]           ff_zw_q, ff_zw_d;
`endif

  assign obs_zw = {gp.dut_z, gp.dut_w};

  // Case-inequality lets an undriven or X output count as a failure in
  // simulation; hardware only ever sees 0/1.
`ifdef SYNTHESIS
  assign mismatch = (obs_zw != exp_zw(vec_q));
`else
  assign mismatch = (obs_zw !== exp_zw(vec_q));
`endif

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    round_d    = round_q;
    ab_d       = ab_q;
    fail_vec_d = fail_vec_q;
    err_clr    = 1'b0;
    err_inc    = 1'b0;
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
    ff_valid_d = ff_valid_q;
    ff_vec_d   = ff_vec_q;
    ff_zw_d    = ff_zw_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d      = '0;
          cnt_d      = '0;
          round_d    = '0;
          ab_d       = 2'b00;
          fail_vec_d = '0;
          err_clr    = 1'b1;
          state_d    = SETTLE;
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
          ff_valid_d = 1'b0;
          ff_vec_d   = '0;
          ff_zw_d    = '0;
`endif
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_inc           = 1'b1;
          fail_vec_d[vec_q] = 1'b1;
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_vec_d   = vec_q;
            ff_zw_d    = obs_zw;
          end
`endif
        end
        if ((vec_q == VEC_LAST) && (round_q == ROUND_LAST)) begin
          ab_d    = 2'b00;
          state_d = DONE;
        end else begin
          vec_d = vec_q + 2'd1;  // 3 -> 0 wraps naturally
          if (vec_q == VEC_LAST) begin
            round_d = round_q + 1'b1;
          end
          cnt_d   = '0;
          ab_d    = vec_q + 2'd1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      round_q    <= '0;
      ab_q       <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_vec_q <= '0;
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      ff_zw_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      round_q    <= round_d;
      ab_q       <= ab_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_vec_q <= fail_vec_d;
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
      ff_valid_q <= ff_valid_d;
      ff_vec_q   <= ff_vec_d;
      ff_zw_q    <= ff_zw_d;
`endif
    end
  end

  gate_pair_bist_sat_cnt #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (err_clr),
    .inc   (err_inc),
    .count (err_count)
  );

  assign gp.dut_a = ab_q[1];
  assign gp.dut_b = ab_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = done_q && (err_count == '0);
  assign fail_vec = fail_vec_q;
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_zw    = ff_zw_q;
`endif

endmodule

// File: tb/tb_gate_pair_bist.sv
// tb_gate_pair_bist
//   Directed bench for gate_pair_bist. Instance u0 uses default parameters and
//   a selectable gate-pair model (good, w stuck 0, z/w swapped, z stuck 1).
//   Instance u1 uses ERR_W=2, ROUNDS=10 with z stuck at 1.
//   First-fail outputs are checked when GATE_PAIR_BIST_FIRST_FAIL_EN is defined.
module tb_gate_pair_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start0, start1;
  logic [1:0] mode;

  gate_pair_bist_if gp0 ();
  gate_pair_bist_if gp1 ();

  // Gate-pair models. mode: 0 good, 1 w stuck 0, 2 z/w swapped, 3 z stuck 1.
  assign gp0.dut_z = (mode == 2'd2) ? (gp0.dut_a | gp0.dut_b) :
                     (mode == 2'd3) ? 1'b1 : (gp0.dut_a & gp0.dut_b);
  assign gp0.dut_w = (mode == 2'd1) ? 1'b0 :
                     (mode == 2'd2) ? (gp0.dut_a & gp0.dut_b) : (gp0.dut_a | gp0.dut_b);
  assign gp1.dut_z = 1'b1;
  assign gp1.dut_w = gp1.dut_a | gp1.dut_b;

  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [3:0] err0, fvec0, fvec1;
  logic [1:0] err1;
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
  logic       ffv0, ffv1;
  logic [1:0] ffvec0, ffzw0, ffvec1, ffzw1;
`endif

  gate_pair_bist u0 (
    .clk (clk), .rst (rst), .start (start0), .gp (gp0.master),
    .busy (busy0), .done (done0), .pass (pass0),
    .err_count (err0), .fail_vec (fvec0)
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
    , .first_fail_valid (ffv0), .first_fail_vec (ffvec0), .first_fail_zw (ffzw0)
`endif
  );

  gate_pair_bist #(.ERR_W (2), .ROUNDS (10)) u1 (
    .clk (clk), .rst (rst), .start (start1), .gp (gp1.master),
    .busy (busy1), .done (done1), .pass (pass1),
    .err_count (err1), .fail_vec (fvec1)
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
    , .first_fail_valid (ffv1), .first_fail_vec (ffvec1), .first_fail_zw (ffzw1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse (or hold) start, then count cycles until done. Checks the vector
  // order on the first cycle of each vector. glitch_at injects a one-cycle
  // start pulse while busy.
  task automatic run0(input int glitch_at, input bit hold, output int lat, output int busy_n);
    start0 = 1'b1;
    tick();
    start0 = hold;
    lat    = 0;
    busy_n = 0;
    while (!done0 && lat < 200) begin
      lat++;
      if (busy0) busy_n++;
      if (((lat - 1) % 3 == 0) && (lat <= 12))
        chk("vec_order", {30'd0, gp0.dut_a, gp0.dut_b}, (lat - 1) / 3);
      start0 = hold || (lat == glitch_at);
      tick();
    end
    chk("done_reached", done0, 1);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         err;
    int         fvec;
    int         pass;
    int         ffv;
    int         ffvec;
    int         ffzw;
  } row_t;

  row_t tbl[4];
  int   lat, bn;

  initial begin
    tbl[0] = '{2'd0, 0, 4'b0000, 1, 0, 0, 0};
    tbl[1] = '{2'd1, 3, 4'b1110, 0, 1, 1, 0};
    tbl[2] = '{2'd2, 2, 4'b0110, 0, 1, 1, 2};
    tbl[3] = '{2'd3, 3, 4'b0111, 0, 1, 0, 2};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 2'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_fvec", fvec0, 0);
    chk("rst_ab", {gp0.dut_a, gp0.dut_b}, 0);
    chk("rst_u1_done", done1, 0);
    $display("[TB] reset state checked");

    // Table: consecutive runs, each restarting from DONE.
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run0(0, 1'b0, lat, bn);
      chk("latency", lat, 12);
      chk("busy_cycles", bn, 12);
      chk("pass", pass0, tbl[i].pass);
      chk("err_count", err0, tbl[i].err);
      chk("fail_vec", fvec0, tbl[i].fvec);
      chk("ab_idle", {gp0.dut_a, gp0.dut_b}, 0);
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
      chk("ff_valid", ffv0, tbl[i].ffv);
      if (tbl[i].ffv != 0) begin
        chk("ff_vec", ffvec0, tbl[i].ffvec);
        chk("ff_zw", ffzw0, tbl[i].ffzw);
      end
`endif
      $display("[TB] row %0d mode %0d lat=%0d err=%0d fvec=%b pass=%0d", i, mode, lat, err0, fvec0, pass0);
    end

    // start held high across DONE: immediate restart, done high one cycle.
    mode = 2'd0;
    run0(0, 1'b1, lat, bn);
    chk("held_latency", lat, 12);
    tick();
    chk("held_done_one_cycle", done0, 0);
    chk("held_busy_restart", busy0, 1);
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 200) begin
      lat++;
      tick();
    end
    chk("held_rerun_latency", lat, 12);
    chk("held_rerun_pass", pass0, 1);
    $display("[TB] held start restart lat=%0d pass=%0d", lat, pass0);

    // Reset mid-run, then a clean run with a start pulse while busy.
    mode = 2'd3;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    chk("mid_ab", {gp0.dut_a, gp0.dut_b}, 1);
    chk("mid_err", err0, 1);
    chk("mid_fvec", fvec0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_err", err0, 0);
    chk("abort_fvec", fvec0, 0);
    chk("abort_ab", {gp0.dut_a, gp0.dut_b}, 0);
    mode = 2'd0;
    run0(4, 1'b0, lat, bn);
    chk("glitch_latency", lat, 12);
    chk("glitch_pass", pass0, 1);
    chk("glitch_err", err0, 0);
    $display("[TB] abort and restart lat=%0d pass=%0d", lat, pass0);

    // Saturation: 10 rounds, 30 mismatches into a 2-bit counter.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 1000) begin
      lat++;
      tick();
    end
    chk("sat_done", done1, 1);
    chk("sat_latency", lat, 120);
    chk("sat_err", err1, 3);
    chk("sat_fvec", fvec1, 4'b0111);
    chk("sat_pass", pass1, 0);
`ifdef GATE_PAIR_BIST_FIRST_FAIL_EN
    chk("sat_ff_valid", ffv1, 1);
    chk("sat_ff_vec", ffvec1, 0);
    chk("sat_ff_zw", ffzw1, 2);
`endif
    $display("[TB] saturation lat=%0d err=%0d fvec=%b", lat, err1, fvec1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
